// File: rtl/axi4_s2mm_burst_writer.sv
// AXI4-Stream to AXI4 memory-mapped burst writer; keeps one burst outstanding at a time.
// Define S2MM_BOUNDARY_4K_EN to also split bursts so none crosses a 4 KiB address boundary.
module axi4_s2mm_burst_writer #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_ID_WIDTH   = 1,
  parameter int C_MAX_BURST_LEN  = 16,
  parameter int C_LEN_WIDTH      = 16
) (
  input  logic                          aclk,
  input  logic                          arstn,

  input  logic                          start,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   base_addr,
  input  logic [C_LEN_WIDTH-1:0]        num_beats,
  output logic                          busy,
  output logic                          done,
  output logic                          error,

  input  logic [C_AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,

  output logic [C_AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,

  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,

  input  logic [C_AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,

  output logic                          m_axi_arvalid,
  output logic                          m_axi_rready
);

  localparam int BYTES  = C_AXI_DATA_WIDTH / 8;
  localparam int AXSIZE = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } state_t;

  state_t                      state;
  logic [C_AXI_ADDR_WIDTH-1:0] addr;
  logic [C_LEN_WIDTH-1:0]      remaining;
  logic [8:0]                  burst_len;
  logic [8:0]                  beat;

  logic                        in_data;
  logic                        last_beat;
  logic                        w_hs;
  logic [C_AXI_ADDR_WIDTH-1:0] next_addr;
  logic [C_LEN_WIDTH-1:0]      next_rem;
  logic [8:0]                  start_len;
  logic [8:0]                  next_len;
  logic                        unused_bid;

  function automatic logic [8:0] clamp_max(input logic [C_LEN_WIDTH-1:0] rem);
    clamp_max = (32'(rem) > 32'(C_MAX_BURST_LEN)) ? 9'(C_MAX_BURST_LEN) : 9'(rem);
  endfunction

`ifdef S2MM_BOUNDARY_4K_EN
  // Beats left before the next 4 KiB page, assuming beat-aligned addresses.
  function automatic logic [8:0] clamp_4k(input logic [8:0] len, input logic [11:0] offset);
    logic [12:0] to_4k;
    to_4k    = (13'd4096 - {1'b0, offset}) >> AXSIZE;
    clamp_4k = (to_4k < {4'b0000, len}) ? to_4k[8:0] : len;
  endfunction

  assign start_len = clamp_4k(clamp_max(num_beats), base_addr[11:0]);
  assign next_len  = clamp_4k(clamp_max(next_rem), next_addr[11:0]);
`else
  assign start_len = clamp_max(num_beats);
  assign next_len  = clamp_max(next_rem);
`endif

  assign next_addr = addr + (C_AXI_ADDR_WIDTH'(burst_len) << AXSIZE);
  assign next_rem  = remaining - C_LEN_WIDTH'(burst_len);

  assign in_data   = (state == S_DATA);
  assign last_beat = (beat == burst_len - 9'd1);
  assign w_hs      = in_data & s_axis_tvalid & m_axi_wready;

  // Write channel is a straight pass-through of the stream while a burst is in DATA.
  assign m_axi_wvalid  = in_data & s_axis_tvalid;
  assign s_axis_tready = in_data & m_axi_wready;
  assign m_axi_wdata   = in_data ? s_axis_tdata : '0;
  assign m_axi_wstrb   = in_data ? '1 : '0;
  assign m_axi_wlast   = in_data & last_beat;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr;
  assign m_axi_awsize  = 3'(AXSIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;
  assign unused_bid    = ^m_axi_bid;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_awlen   <= 8'd0;
      addr          <= '0;
      remaining     <= '0;
      burst_len     <= 9'd0;
      beat          <= 9'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (num_beats == '0) begin
              done <= 1'b1;
            end else begin
              addr          <= base_addr;
              remaining     <= num_beats;
              burst_len     <= start_len;
              m_axi_awlen   <= 8'(start_len - 9'd1);
              m_axi_awvalid <= 1'b1;
              busy          <= 1'b1;
              error         <= 1'b0;
              state         <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            beat          <= 9'd0;
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            if (last_beat) begin
              m_axi_bready <= 1'b1;
              state        <= S_RESP;
            end else begin
              beat <= beat + 9'd1;
            end
          end
        end
        // A failed response is recorded but the transfer still runs to completion.
        S_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != 2'b00) error <= 1'b1;
            addr      <= next_addr;
            remaining <= next_rem;
            if (next_rem == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              burst_len     <= next_len;
              m_axi_awlen   <= 8'(next_len - 9'd1);
              m_axi_awvalid <= 1'b1;
              state         <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_s2mm_burst_writer.sv
// Randomized self-checking bench for axi4_s2mm_burst_writer with a transaction-level model.
// Expected bursts come from plain arithmetic on (base, beats); define S2MM_BOUNDARY_4K_EN to match the DUT build.
module tb_axi4_s2mm_burst_writer;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int IW    = 1;
  localparam int MAXB  = 16;
  localparam int LW    = 16;
  localparam int BYTES = DW / 8;
  localparam int SMEM  = 2048;

  logic            aclk = 1'b0;
  logic            arstn;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [LW-1:0]   num_beats;
  logic            busy, done, error;
  logic [DW-1:0]   s_axis_tdata;
  logic            s_axis_tvalid, s_axis_tready;
  logic [IW-1:0]   m_axi_awid;
  logic [AW-1:0]   m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic            m_axi_awvalid, m_axi_awready;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [IW-1:0]   m_axi_bid;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid, m_axi_bready;
  logic            m_axi_arvalid, m_axi_rready;

  always #5 aclk = ~aclk;

  axi4_s2mm_burst_writer #(
    .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .C_AXI_ID_WIDTH(IW),
    .C_MAX_BURST_LEN(MAXB), .C_LEN_WIDTH(LW)
  ) dut (
    .aclk(aclk), .arstn(arstn),
    .start(start), .base_addr(base_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .error(error),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_rready(m_axi_rready)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus-side state: stream source contents, stall enable and slave B responder.
  logic [DW-1:0] stream_mem [SMEM];
  logic          stall_en = 1'b0;
  int            err_burst = -1;
  int            sidx = 0;
  int            b_owed = 0;
  int            b_idx = 0;
  logic          b_taken;

  always begin
    @(negedge aclk);
    b_taken = 1'b0;
    if (arstn) begin
      if (s_axis_tvalid && s_axis_tready) sidx++;
      if (m_axi_wvalid && m_axi_wready && m_axi_wlast) b_owed++;
      if (m_axi_bvalid && m_axi_bready) begin
        b_taken = 1'b1;
        b_idx++;
      end
    end
    @(posedge aclk);
    #1;
    if (b_taken || !arstn) m_axi_bvalid = 1'b0;
    if (!arstn) b_owed = 0;
    m_axi_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi_wready  = stall_en ? ($urandom_range(0, 9) < 7) : 1'b1;
    s_axis_tvalid = stall_en ? ($urandom_range(0, 9) < 7) : 1'b1;
    s_axis_tdata  = stream_mem[sidx % SMEM];
    if (!m_axi_bvalid && b_owed > 0 && arstn && (!stall_en || $urandom_range(0, 2) == 0)) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
      b_owed--;
    end
  end

  // Transaction-level model: a queue of expected bursts plus phase flags driven by handshakes.
  logic          m_busy = 1'b0, m_done = 1'b0, m_error = 1'b0;
  logic          m_aw = 1'b0, in_w = 1'b0, in_b = 1'b0;
  int            m_beat = 0, widx = 0, xfer_beat = 0, total_aw = 0, done_cnt = 0;
  logic [31:0]   q_addr[$];
  int            q_len[$];
  logic [31:0]   aw_addr_log[$];
  int            aw_len_log[$];
  int            wlast_log[$];
  longint        ma;
  int            mrem, ml, mb;
  logic          wb, wd;

  always begin
    @(negedge aclk);
    if (!arstn) begin
      m_busy = 0; m_done = 0; m_error = 0; m_aw = 0; in_w = 0; in_b = 0; m_beat = 0;
      q_addr.delete(); q_len.delete();
    end
    checkOutput("busy", busy, m_busy);
    checkOutput("done", done, m_done);
    checkOutput("error", error, m_error);
    checkOutput("awvalid", m_axi_awvalid, m_aw);
    if (m_aw && q_len.size() > 0) begin
      checkOutput("awaddr", m_axi_awaddr, q_addr[0]);
      checkOutput("awlen", m_axi_awlen, q_len[0] - 1);
      checkOutput("awsize", m_axi_awsize, $clog2(BYTES));
      checkOutput("awburst", m_axi_awburst, 2'b01);
      checkOutput("awid", m_axi_awid, 0);
    end
    checkOutput("wvalid", m_axi_wvalid, in_w ? s_axis_tvalid : 1'b0);
    checkOutput("tready", s_axis_tready, in_w ? m_axi_wready : 1'b0);
    checkOutput("wdata", m_axi_wdata, in_w ? s_axis_tdata : '0);
    checkOutput("wstrb", m_axi_wstrb, in_w ? {(DW/8){1'b1}} : '0);
    checkOutput("wlast", m_axi_wlast, (in_w && q_len.size() > 0) ? (m_beat == q_len[0] - 1) : 1'b0);
    checkOutput("bready", m_axi_bready, in_b);
    checkOutput("arvalid_rready", {m_axi_arvalid, m_axi_rready}, 2'b00);
    if (done) done_cnt++;

    if (arstn) begin
      wb = m_busy;
      wd = m_done;
      m_done = 0;
      if (wb && wd) begin
        m_busy = 0;
      end else if (!wb && start) begin
        if (num_beats == 0) begin
          m_done = 1;
        end else begin
          q_addr.delete(); q_len.delete();
          aw_addr_log.delete(); aw_len_log.delete(); wlast_log.delete();
          ma = base_addr;
          mrem = int'(num_beats);
          while (mrem > 0) begin
            ml = (mrem < MAXB) ? mrem : MAXB;
`ifdef S2MM_BOUNDARY_4K_EN
            mb = int'((4096 - (ma % 4096)) / BYTES);
            if (mb < ml) ml = mb;
`endif
            q_addr.push_back(32'(ma));
            q_len.push_back(ml);
            ma = ma + longint'(ml * BYTES);
            mrem = mrem - ml;
          end
          m_busy = 1; m_error = 0; m_aw = 1; xfer_beat = 0;
        end
      end else if (m_aw && m_axi_awready) begin
        aw_addr_log.push_back(m_axi_awaddr);
        aw_len_log.push_back(int'(m_axi_awlen));
        total_aw++;
        m_aw = 0; in_w = 1; m_beat = 0;
      end else if (in_w && s_axis_tvalid && m_axi_wready) begin
        checkOutput("wdata_order", m_axi_wdata, stream_mem[widx % SMEM]);
        widx++; m_beat++; xfer_beat++;
        if (m_axi_wlast) wlast_log.push_back(xfer_beat);
        if (m_beat == q_len[0]) begin
          in_w = 0; in_b = 1;
        end
      end else if (in_b && m_axi_bvalid) begin
        in_b = 0;
        if (m_axi_bresp != 2'b00) m_error = 1;
        void'(q_addr.pop_front());
        void'(q_len.pop_front());
        if (q_len.size() == 0) m_done = 1;
        else m_aw = 1;
      end
    end
  end

  task automatic applyStimulus(input logic [AW-1:0] base, input int beats);
    @(posedge aclk);
    #1;
    start = 1'b1; base_addr = base; num_beats = LW'(beats);
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    logic got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge aclk);
      if (done) got = 1'b1;
    end
    if (!got) checkOutput({name, "_done_timeout"}, 0, 1);
    repeat (3) @(negedge aclk);
  endtask

  task automatic runTransfer(input string name, input logic [AW-1:0] base, input int beats, input int errb);
    b_idx = 0;
    err_burst = errb;
    done_cnt = 0;
    applyStimulus(base, beats);
    waitDone(name, 4000);
  endtask

  task automatic checkBursts(input string name, input int n, input logic [31:0] ea[4], input int el[4]);
    checkOutput({name, "_aw_count"}, aw_addr_log.size(), n);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_awaddr%0d", name, i), (i < aw_addr_log.size()) ? aw_addr_log[i] : 32'hFFFF_FFFF, ea[i]);
      checkOutput($sformatf("%s_awlen%0d", name, i), (i < aw_len_log.size()) ? aw_len_log[i] : -1, el[i]);
    end
  endtask

  logic [31:0] ea[4];
  int          el[4];
  int          n31, prev_aw, rbeats, rerr;
  logic [31:0] rbase;
  logic        hit;

  initial begin
    for (int i = 0; i < SMEM; i++) stream_mem[i] = $urandom;
    arstn = 1'b0; start = 1'b0; base_addr = '0; num_beats = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bid = '0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done_error", {done, error}, 2'b00);
    checkOutput("rst_awvalid_bready", {m_axi_awvalid, m_axi_bready}, 2'b00);
    @(posedge aclk);
    #1;
    arstn = 1'b1;

    $display("[TB] always-ready transfer of 40 beats from 0x1000");
    runTransfer("t40", 32'h1000, 40, -1);
    ea = '{32'h1000, 32'h1040, 32'h1080, 0};
    el = '{15, 15, 7, 0};
    checkBursts("t40", 3, ea, el);
    checkOutput("t40_done_pulses", done_cnt, 1);

    $display("[TB] 8 beats from 0x0FF0 near a 4 KiB page edge");
    runTransfer("t4k", 32'h0FF0, 8, -1);
`ifdef S2MM_BOUNDARY_4K_EN
    n31 = 2; ea = '{32'h0FF0, 32'h1000, 0, 0}; el = '{3, 3, 0, 0};
`else
    n31 = 1; ea = '{32'h0FF0, 0, 0, 0}; el = '{7, 0, 0, 0};
`endif
    checkBursts("t4k", n31, ea, el);

    $display("[TB] 64 beats with random stalls");
    stall_en = 1'b1;
    runTransfer("t64", 32'h2000, 64, -1);
    checkOutput("t64_beats", xfer_beat, 64);
    checkOutput("t64_wlast_count", wlast_log.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t64_wlast%0d", i), (i < wlast_log.size()) ? wlast_log[i] : -1, 16 * (i + 1));

    $display("[TB] SLVERR on the second burst");
    runTransfer("terr", 32'h3000, 40, 1);
    checkOutput("terr_error_sticky", error, 1);
    checkOutput("terr_aw_count", aw_addr_log.size(), 3);
    b_idx = 0; err_burst = -1;
    applyStimulus(32'h4000, 4);
    checkOutput("terr_error_cleared", error, 0);
    waitDone("terr2", 4000);

    $display("[TB] zero-beat start and start while busy");
    prev_aw = total_aw;
    applyStimulus(32'h5000, 0);
    checkOutput("tzero_done", done, 1);
    repeat (3) @(negedge aclk);
    checkOutput("tzero_no_aw", total_aw, prev_aw);
    b_idx = 0;
    applyStimulus(32'h6000, 20);
    repeat (4) @(posedge aclk);
    #1;
    start = 1'b1; base_addr = 32'h9000; num_beats = LW'(5);
    @(posedge aclk);
    #1;
    start = 1'b0;
    waitDone("tbusy", 4000);
    checkOutput("tbusy_beats", xfer_beat, 20);
    checkOutput("tbusy_aw_count", aw_addr_log.size(), 2);

    $display("[TB] reset asserted mid-DATA");
    b_idx = 0;
    applyStimulus(32'h7000, 32);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge aclk);
      #1;
      if (in_w && xfer_beat >= 3) hit = 1'b1;
    end
    if (!hit) checkOutput("trst_reach_data_timeout", 0, 1);
    @(posedge aclk);
    #2;
    arstn = 1'b0;
    #1;
    checkOutput("trst_busy_done_error", {busy, done, error}, 3'b000);
    checkOutput("trst_aw_b", {m_axi_awvalid, m_axi_bready}, 2'b00);
    checkOutput("trst_w", {m_axi_wvalid, m_axi_wlast, s_axis_tready}, 3'b000);
    repeat (2) @(posedge aclk);
    #1;
    arstn = 1'b1;
    runTransfer("trst_after", 32'h8000, 10, -1);
    checkOutput("trst_after_done_pulses", done_cnt, 1);
    checkOutput("trst_after_beats", xfer_beat, 10);

    $display("[TB] random transfers");
    for (int k = 0; k < 5; k++) begin
      rbase  = (32'($urandom_range(0, 15)) << 12) | (32'($urandom_range(0, 1023)) << 2);
      rbeats = $urandom_range(1, 50);
      rerr   = int'($urandom_range(0, 3)) - 1;
      runTransfer($sformatf("trand%0d", k), rbase, rbeats, rerr);
      checkOutput($sformatf("trand%0d_beats", k), xfer_beat, rbeats);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/axi4_s2mm_burst_writer.md
AXI4_S2MM_BURST_WRITER -- requirements
Module: axi4_s2mm_burst_writer

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32: data width of the stream and AXI write data; power of two, 8..256.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 32: AXI address width.
REQ-003 SHALL have parameter C_AXI_ID_WIDTH, default 1: AXI ID width.
REQ-004 SHALL have parameter C_MAX_BURST_LEN, default 16: maximum beats per burst, 1..256.
REQ-005 SHALL have parameter C_LEN_WIDTH, default 16: width of the transfer beat count.
REQ-006 SHALL have port aclk, input, 1: clock; all logic is rising-edge.
REQ-007 SHALL have port arstn, input, 1: asynchronous active-low reset.
REQ-008 SHALL have ports start (input, 1), base_addr (input, C_AXI_ADDR_WIDTH) and num_beats (input, C_LEN_WIDTH): transfer command, sampled on start.
REQ-009 SHALL have outputs busy (1), done (1, single-cycle pulse) and error (1, sticky): transfer status.
REQ-010 SHALL have slave stream ports s_axis_tdata (in, C_AXI_DATA_WIDTH), s_axis_tvalid (in, 1) and s_axis_tready (out, 1).
REQ-011 SHALL have AW outputs m_axi_awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0] and awvalid, plus input m_axi_awready.
REQ-012 SHALL have W outputs m_axi_wdata, wstrb (C_AXI_DATA_WIDTH/8), wlast and wvalid, plus input m_axi_wready.
REQ-013 SHALL have B inputs m_axi_bid, bresp[1:0] and bvalid, plus output m_axi_bready.
REQ-014 SHALL tie all AR/R master outputs to 0: arvalid=0, rready=0.

Function
REQ-015 SHALL implement FSM IDLE -> ADDR -> DATA -> RESP, then either ADDR (beats remain) or DONE; DONE -> IDLE after one cycle.
REQ-016 IDLE: start=1 with num_beats>0 SHALL latch the address and count, set busy the next cycle and clear error; start with num_beats=0 SHALL pulse done the next cycle and issue no AXI traffic.
REQ-017 SHALL ignore start while busy=1.
REQ-018 Burst length SHALL be min(remaining, C_MAX_BURST_LEN, beats to next 4 KiB boundary when enabled), computed on ADDR entry; awlen = length-1.
REQ-019 ADDR: awvalid SHALL be held with stable payload until awready; awsize = log2(C_AXI_DATA_WIDTH/8), awburst=2'b01 (INCR), awid=0.
REQ-020 DATA: wvalid = s_axis_tvalid, s_axis_tready = m_axi_wready, wdata = s_axis_tdata, and wstrb all ones, combinationally; all are 0 outside DATA.
REQ-021 wlast SHALL be 1 exactly on the final beat of each burst; after that beat handshakes, the FSM SHALL go to RESP.
REQ-022 RESP: bready=1; on bvalid, address SHALL advance by length*(C_AXI_DATA_WIDTH/8) and remaining SHALL decrement by length.
REQ-023 bresp != 2'b00 SHALL set error, which stays set until the next accepted start; the transfer SHALL continue to completion.
REQ-024 done SHALL pulse one cycle in DONE; busy SHALL be 1 from the cycle after start until DONE inclusive.
REQ-025 Only one burst SHALL be outstanding; AW for burst N+1 SHALL NOT be issued before B of burst N.

Reset
REQ-026 arstn low SHALL asynchronously force IDLE and set busy, done, error, awvalid, wvalid, wlast, bready and s_axis_tready to 0; this SHALL also apply mid-transfer, with no recovery of the partial transfer.
REQ-027 Deassertion SHALL be synchronised by the user; the block SHALL accept start on the first cycle after release.

Configuration
REQ-028 Macro S2MM_BOUNDARY_4K_EN defined: bursts SHALL additionally split so that no burst crosses a 4096-byte address boundary.
REQ-029 Macro S2MM_BOUNDARY_4K_EN undefined: splitting SHALL use remaining and C_MAX_BURST_LEN only, and the boundary logic SHALL be absent.

Verification
REQ-030 Defaults; base 0x1000, num_beats 40, always-ready slave -> awlen 15,15,7; addresses 0x1000, 0x1040, 0x1080; one done pulse.
REQ-031 With macro; base 0x0FF0, num_beats 8 -> bursts awaddr 0x0FF0 awlen 3, then 0x1000 awlen 3; without macro -> single burst awlen 7.
REQ-032 Random tvalid/wready/awready stalls, 64 beats -> written data equals stream order; wlast on beats 16, 32, 48 and 64 only.
REQ-033 Second burst returns bresp 2'b10 -> error=1 after that B; remaining bursts still issued; error clears on next start.
REQ-034 start with num_beats 0 -> done the next cycle, no awvalid; start pulsed during busy -> ignored, beat count unchanged.
REQ-035 arstn asserted mid-DATA -> all outputs 0 the same cycle; a new start after release completes normally.
